hall_call_scheduler: RTL and testbench

Collects hall-call button presses (up/down) from every floor, latches them as pending calls, and drives the hall lamps from the latched state. Dispatches one pending call at a time to the building/car controller over a valid/ready handshake, using a round-robin order. Holds that call outstanding until the controller reports it serviced. Sits between the per-floor hall button panels and the building controller.

---
 rtl/hall_call_scheduler.sv | 129 ++++++++++++
 tb/tb_hall_call_scheduler.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hall_call_scheduler.sv
// Hall-call latch and round-robin dispatcher: pending up/down calls drive the lamps,
// and one call at a time is offered to the car controller and held until serviced.
module hall_call_scheduler #(
  parameter int NUM_FLOORS = 4,
  parameter int FLOOR_W    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] hall_up_req,
  input  logic [NUM_FLOORS-1:0] hall_dn_req,
  output logic                  disp_valid,
  input  logic                  disp_ready,
  output logic [FLOOR_W-1:0]    disp_floor,
  output logic                  disp_dir_up_ndown,
  input  logic                  service_valid,
  input  logic [FLOOR_W-1:0]    service_floor,
  input  logic                  service_dir_up_ndown,
  output logic [NUM_FLOORS-1:0] hall_up_lamp,
  output logic [NUM_FLOORS-1:0] hall_dn_lamp,
  output logic                  busy,
  output logic [1:0]            fsm_state
);

  localparam int SLOTS  = 2 * NUM_FLOORS;
  localparam int SLOT_W = FLOOR_W + 1;
  // Top floor has no up button, bottom floor has no down button.
  localparam logic [NUM_FLOORS-1:0] UP_MASK = {1'b0, {(NUM_FLOORS-1){1'b1}}};
  localparam logic [NUM_FLOORS-1:0] DN_MASK = {{(NUM_FLOORS-1){1'b1}}, 1'b0};

  // Handshake: a call transfers on a cycle where disp_valid and disp_ready are both 1;
  // while disp_valid is 1 the offered floor/direction stay stable unless the call is
  // serviced first, in which case the offer is withdrawn.
  typedef enum logic [1:0] {IDLE = 2'd0, OFFER = 2'd1, BUSY = 2'd2} state_t;

  state_t            state, state_next;
  logic [SLOTS-1:0]  pending, set_vec, clr_vec, offered_mask, eligible;
  logic [NUM_FLOORS-1:0] up_eff, dn_eff;
  logic [SLOT_W-1:0] rr_last, cur_slot, svc_slot, win_slot, cand;
  logic              win_found, svc_in_range, svc_match;
  logic              load_grant, take_hs;
  int                t;

  assign up_eff       = hall_up_req & UP_MASK;
  assign dn_eff       = hall_dn_req & DN_MASK;
  assign cur_slot     = {disp_floor, disp_dir_up_ndown};
  assign svc_slot     = {service_floor, service_dir_up_ndown};
  assign svc_in_range = 32'(service_floor) < NUM_FLOORS;
  assign svc_match    = service_valid && (svc_slot == cur_slot);

  for (genvar f = 0; f < NUM_FLOORS; f++) begin : g_floor
    assign set_vec[2*f+1]  = up_eff[f];
    assign set_vec[2*f]    = dn_eff[f];
    assign hall_up_lamp[f] = pending[2*f+1];
    assign hall_dn_lamp[f] = pending[2*f];
  end

  for (genvar s = 0; s < SLOTS; s++) begin : g_slot
    assign clr_vec[s]      = service_valid && svc_in_range && (svc_slot == SLOT_W'(s));
    assign offered_mask[s] = (state != IDLE) && (cur_slot == SLOT_W'(s));
  end

  assign eligible = pending & ~offered_mask;

  always_comb begin
    win_found = 1'b0;
    win_slot  = rr_last;
    t         = 0;
    cand      = '0;
    for (int i = 1; i <= SLOTS; i++) begin
      t = int'(rr_last) + i;
      if (t >= SLOTS) t = t - SLOTS;
      cand = SLOT_W'(t);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_slot  = cand;
      end
    end
  end

  always_comb begin
    state_next = state;
    load_grant = 1'b0;
    take_hs    = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_next = OFFER;
          load_grant = 1'b1;
        end
      end
      OFFER: begin
        // A handshake wins over a same-cycle service of the offered call.
        if (disp_ready) begin
          take_hs    = 1'b1;
          state_next = svc_match ? IDLE : BUSY;
        end else if (svc_match) begin
          state_next = IDLE;
        end
      end
      BUSY: begin
        if (svc_match) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending           <= '0;
      rr_last           <= SLOT_W'(SLOTS - 1);
      disp_floor        <= '0;
      disp_dir_up_ndown <= 1'b0;
    end else begin
      pending <= (pending | set_vec) & ~clr_vec;
      if (load_grant) {disp_floor, disp_dir_up_ndown} <= win_slot;
      if (take_hs)    rr_last <= cur_slot;
    end
  end

  assign disp_valid = (state == OFFER);
  assign busy       = (state == BUSY);
  assign fsm_state  = state;

endmodule

// File: tb/tb_hall_call_scheduler.sv
// Bench for hall_call_scheduler: directed scenarios plus random traffic, all checked
// cycle by cycle against a slot-array reference model and a grant scoreboard.
module tb_hall_call_scheduler;

  localparam int N     = 4;
  localparam int FW    = 2;
  localparam int SLOTS = 2 * N;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]  up_req = '0, dn_req = '0;
  logic          disp_ready = 1'b0, service_valid = 1'b0, service_dir = 1'b0;
  logic [FW-1:0] service_floor = '0;
  logic          disp_valid, disp_dir, busy;
  logic [FW-1:0] disp_floor;
  logic [N-1:0]  hall_up_lamp, hall_dn_lamp;
  logic [1:0]    fsm_state;

  hall_call_scheduler #(.NUM_FLOORS(N), .FLOOR_W(FW)) dut (
    .clk(clk), .reset(reset),
    .hall_up_req(up_req), .hall_dn_req(dn_req),
    .disp_valid(disp_valid), .disp_ready(disp_ready),
    .disp_floor(disp_floor), .disp_dir_up_ndown(disp_dir),
    .service_valid(service_valid), .service_floor(service_floor),
    .service_dir_up_ndown(service_dir),
    .hall_up_lamp(hall_up_lamp), .hall_dn_lamp(hall_dn_lamp),
    .busy(busy), .fsm_state(fsm_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0] exp_q[$];
  int got_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model: one pending bit per slot, plus the single offered/outstanding call
  bit m_pend[SLOTS];
  bit m_offering, m_outstanding;
  int m_slot, m_rr;

  task automatic model_reset();
    for (int s = 0; s < SLOTS; s++) m_pend[s] = 1'b0;
    m_offering = 1'b0;
    m_outstanding = 1'b0;
    m_slot = 0;
    m_rr = SLOTS - 1;
    exp_q.delete();
  endtask

  function automatic int m_pick();
    for (int i = 1; i <= SLOTS; i++) begin
      int s = (m_rr + i) % SLOTS;
      if (m_pend[s] && !((m_offering || m_outstanding) && s == m_slot)) return s;
    end
    return -1;
  endfunction

  task automatic model_step();
    int win = m_pick();
    int svc = int'(service_floor) * 2 + int'(service_dir);
    bit match = service_valid && (svc == m_slot);
    bit nxt[SLOTS];
    for (int f = 0; f < N; f++) begin
      nxt[2*f+1] = m_pend[2*f+1] | (up_req[f] && f != N - 1);
      nxt[2*f]   = m_pend[2*f]   | (dn_req[f] && f != 0);
    end
    if (service_valid && int'(service_floor) < N) nxt[svc] = 1'b0;
    if (m_offering) begin
      if (disp_ready) begin
        exp_q.push_back(4'(m_slot));
        m_rr = m_slot;
        m_offering = 1'b0;
        m_outstanding = !match;
      end else if (match) begin
        m_offering = 1'b0;
      end
    end else if (m_outstanding) begin
      if (match) m_outstanding = 1'b0;
    end else if (win >= 0) begin
      m_offering = 1'b1;
      m_slot = win;
    end
    for (int s = 0; s < SLOTS; s++) m_pend[s] = nxt[s];
  endtask

  // one clock: apply current inputs, advance the model, compare all outputs
  task automatic tick();
    bit dut_hs = disp_valid && disp_ready;
    int dut_slot = int'({disp_floor, disp_dir});
    logic [N-1:0] eu, ed;
    @(posedge clk);
    model_step();
    #1;
    if (dut_hs) begin
      got_q.push_back(dut_slot);
      if (exp_q.size() == 0) check("unexpected_grant", 1, 0);
      else begin
        logic [3:0] e = exp_q.pop_front();
        check("grant_slot", dut_slot, e);
      end
    end
    for (int f = 0; f < N; f++) begin
      eu[f] = m_pend[2*f+1];
      ed[f] = m_pend[2*f];
    end
    check("up_lamp", hall_up_lamp, eu);
    check("dn_lamp", hall_dn_lamp, ed);
    check("disp_valid", disp_valid, m_offering);
    check("busy", busy, m_outstanding);
    if (m_offering) check("disp_slot", {disp_floor, disp_dir}, m_slot);
  endtask

  task automatic clear_inputs();
    up_req = '0; dn_req = '0; disp_ready = 1'b0;
    service_valid = 1'b0; service_floor = '0; service_dir = 1'b0;
  endtask

  task automatic service(input int slot);
    service_valid = 1'b1;
    service_floor = FW'(slot / 2);
    service_dir   = slot[0];
  endtask

  task automatic do_reset();
    reset = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    check("rst_valid", disp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_lamps", {hall_up_lamp, hall_dn_lamp}, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // controller that accepts every offer and services it on the next cycle
  task automatic run_ctrl(input int cycles);
    int ctrl_slot = 0;
    for (int c = 0; c < cycles; c++) begin
      disp_ready = 1'b1;
      if (busy) service(ctrl_slot);
      else service_valid = 1'b0;
      if (disp_valid) ctrl_slot = int'({disp_floor, disp_dir});
      tick();
      up_req = '0; dn_req = '0;
    end
    service_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int held;
    model_reset();

    // basic dispatch
    do_reset();
    up_req = 4'b0010; disp_ready = 1'b1;
    tick();
    check("basic_lamp", hall_up_lamp, 4'b0010);
    check("basic_no_valid_yet", disp_valid, 0);
    up_req = '0;
    tick();
    check("basic_valid", disp_valid, 1);
    check("basic_floor_dir", {disp_floor, disp_dir}, 3'b011);
    tick();
    check("basic_busy", busy, 1);
    disp_ready = 1'b0; service(3);
    tick();
    check("basic_lamp_clr", hall_up_lamp, 4'b0000);
    check("basic_busy_clr", busy, 0);
    clear_inputs();

    // end-floor masking
    seen = 0;
    up_req = 4'b1000; dn_req = 4'b0001; disp_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (disp_valid) seen++;
    end
    check("mask_lamps", {hall_up_lamp, hall_dn_lamp}, 0);
    check("mask_no_offer", seen, 0);
    clear_inputs();

    // round robin
    do_reset();
    got_q.delete();
    up_req[0] = 1'b1; dn_req[2] = 1'b1; dn_req[3] = 1'b1;
    run_ctrl(12);
    up_req[0] = 1'b1; dn_req[1] = 1'b1;
    run_ctrl(10);
    check("rr_count", got_q.size(), 5);
    if (got_q.size() == 5) begin
      check("rr_g0", got_q[0], 1);
      check("rr_g1", got_q[1], 4);
      check("rr_g2", got_q[2], 6);
      check("rr_g3", got_q[3], 1);
      check("rr_g4", got_q[4], 2);
    end
    clear_inputs();

    // offer stability and withdrawal
    up_req[2] = 1'b1;
    tick();
    up_req = '0;
    tick();
    check("stab_offer", {disp_valid, disp_floor, disp_dir}, 4'b1101);
    for (int c = 0; c < 5; c++) begin
      tick();
      check("stab_hold", {disp_valid, disp_floor, disp_dir}, 4'b1101);
    end
    service(5);
    tick();
    check("withdraw_valid", disp_valid, 0);
    check("withdraw_lamp", hall_up_lamp[2], 0);
    clear_inputs();
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (disp_valid) seen++;
    end
    check("withdraw_no_reoffer", seen, 0);

    // same-cycle set/clear, then handshake together with matching service
    dn_req[2] = 1'b1; service(4);
    tick();
    check("setclr_lamp", hall_dn_lamp[2], 0);
    service_valid = 1'b0;
    tick();
    check("reset_by_hold", hall_dn_lamp[2], 1);
    dn_req = '0;
    tick();
    check("sc_offer", {disp_valid, disp_floor, disp_dir}, 4'b1100);
    disp_ready = 1'b1; service(4);
    tick();
    check("sc_busy", busy, 0);
    check("sc_valid", disp_valid, 0);
    clear_inputs();
    up_req[0] = 1'b1; dn_req[2] = 1'b1;
    tick();
    clear_inputs();
    tick();
    check("sc_rr_advanced", {disp_valid, disp_floor, disp_dir}, 4'b1001);

    // async reset in the middle of an offer
    do_reset();
    up_req = 4'b0011; dn_req = 4'b1000;
    tick();
    clear_inputs();
    tick();
    check("pre_rst_lamps", {hall_up_lamp, hall_dn_lamp}, 8'b0011_1000);
    check("pre_rst_valid", disp_valid, 1);
    #3;
    reset = 1'b0;
    #1;
    check("async_valid", disp_valid, 0);
    check("async_busy", busy, 0);
    check("async_lamps", {hall_up_lamp, hall_dn_lamp}, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    up_req[2] = 1'b1; dn_req[1] = 1'b1;
    tick();
    clear_inputs();
    tick();
    check("post_rst_first", {disp_valid, disp_floor, disp_dir}, 4'b1010);

    // random traffic
    do_reset();
    held = 0;
    for (int c = 0; c < 3000; c++) begin
      up_req = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      dn_req = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      disp_ready = ($urandom_range(0, 2) != 0);
      service_valid = 1'b0;
      if (busy && $urandom_range(0, 2) == 0) service(int'({disp_floor, disp_dir}));
      else if (disp_valid && $urandom_range(0, 7) == 0) service(int'({disp_floor, disp_dir}));
      else if ($urandom_range(0, 5) == 0) service(int'($urandom_range(0, SLOTS - 1)));
      tick();
      if (busy) held++;
    end
    clear_inputs();
    tick();
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
